// File: rtl/io_input_pkg.sv
// Shared types and register offsets for the memory-mapped input port.
package io_input_pkg;

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    XOR = 2'd2
  } calc_mode_t;

  localparam logic [7:0] IO_SW_OFS   = 8'h00;
  localparam logic [7:0] IO_KEY_OFS  = 8'h10;
  localparam logic [7:0] IO_EV_OFS   = 8'h14;
  localparam logic [7:0] IO_MODE_OFS = 8'h18;

  localparam int NUM_SW  = 10;
  localparam int NUM_KEY = 3;
  localparam int NUM_IN  = NUM_SW + NUM_KEY;

endpackage

// File: rtl/io_debounce.sv
// One-bit input conditioner: 2-flop synchroniser, optional polarity flip, debounce.
// Debounce counter is built only when IO_INPUT_DEBOUNCE_EN is defined.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
  parameter bit RST_VAL         = 1'b0,
  parameter bit INVERT          = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw,
  output logic stable
);

  logic s1, s2, sync;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Keys reset to "released" raw level, which inverts to 0 here.
  assign sync = s2 ^ INVERT;

`ifdef IO_INPUT_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;
  logic             stable_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else if (sync == stable_q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_q <= sync;
      cnt      <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stable = stable_q;
`else
  assign stable = sync;
`endif

endmodule

// File: rtl/io_input_port.sv
// Switch/key input stage for sc_datamem's I/O window: conditioning, press events,
// calculator mode and registered read mux. Debounce enabled by IO_INPUT_DEBOUNCE_EN.
module io_input_port
  import io_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [9:0]  sw,
  input  logic [3:1]  key,
  input  logic        rd_en,
  input  logic [7:0]  rd_addr,
  output logic [31:0] rdata,
  output logic [9:0]  sw_stable,
  output logic [2:0]  key_pressed,
  output logic [1:0]  mode
);

  logic [NUM_IN-1:0] raw, stable;
  logic [2:0]        key_prev, ev, press;
  logic              ev_clr;
  calc_mode_t        mode_q;

  assign raw = {key, sw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    io_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W),
      .RST_VAL        (i >= NUM_SW),
      .INVERT         (i >= NUM_SW)
    ) u_db (
      .clock (clock),
      .resetn(resetn),
      .raw   (raw[i]),
      .stable(stable[i])
    );
  end

  assign sw_stable   = stable[NUM_SW-1:0];
  assign key_pressed = stable[NUM_IN-1:NUM_SW];
  assign press       = key_pressed & ~key_prev;
  assign ev_clr      = rd_en && (rd_addr == IO_EV_OFS);

  // A press landing on the clear edge survives the clear.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      key_prev <= '0;
      ev       <= '0;
    end else begin
      key_prev <= key_pressed;
      ev       <= (ev_clr ? 3'b000 : ev) | press;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn)        mode_q <= ADD;
    else if (press[0])  mode_q <= ADD;
    else if (press[1])  mode_q <= SUB;
    else if (press[2])  mode_q <= XOR;
  end

  assign mode = mode_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      rdata <= '0;
    end else if (rd_en) begin
      case (rd_addr)
        IO_SW_OFS:   rdata <= {22'b0, sw_stable};
        IO_KEY_OFS:  rdata <= {29'b0, key_pressed};
        IO_EV_OFS:   rdata <= {29'b0, ev};
        IO_MODE_OFS: rdata <= {30'b0, mode_q};
        default:     rdata <= '0;
      endcase
    end
  end

endmodule

// File: doc/io_input_port.md
# io_input_port

Memory-mapped input stage of the single-cycle computer. Sits directly upstream of `sc_datamem` and conditions the board switches and push-buttons before the data memory's I/O read path consumes them:
- two-flop synchronisation and per-bit debounce;
- press-edge detection with sticky event flags;
- a calculator-mode register (ADD/SUB/XOR) driven by key presses.

It also provides a registered read port that `sc_datamem` returns on `lw` to the I/O window at 0xFFFFFF00–0xFFFFFF1F.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable cycles required before a synchronised input change is accepted. Must be ≥ 2.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width (derived; do not override).
- `clock` input 1: single system clock, rising edge.
- `resetn` input 1: synchronous, active-low reset.
- `sw` input 10: raw slide switches, asynchronous to `clock`.
- `key` input [3:1]: raw push-buttons, active-low (0 = pressed), asynchronous.
- `rd_en` input 1: read strobe for the I/O window.
- `rd_addr` input 8: byte offset within the window (`addr[7:0]`).
- `rdata` output 32: registered read data.
- `sw_stable` output 10: debounced switch levels.
- `key_pressed` output 3: debounced key levels, active-high (bit0 = key1).
- `mode` output 2: calculator mode. 0 = ADD, 1 = SUB, 2 = XOR; 3 is never produced.

## Operation
- **Synchronisation.** Every raw bit passes through a 2-flop synchroniser. Key bits are inverted after synchronisation, so all downstream logic is active-high.
- **Debounce (per bit).**
  - If the synchronised value equals the stable value, the counter clears to 0.
  - Otherwise the counter increments. When it reaches `DEBOUNCE_CYCLES-1`, the stable value takes the synchronised value and the counter clears.
  - Any bounce back to the stable value before that clears the counter.
- **Press edge.** A press edge is stable key rising 0→1. Release edges are ignored.
- **Event flags `ev[2:0]`.**
  - A press edge sets the matching flag.
  - A read of offset 0x14 clears all flags one cycle after the read.
  - A press edge in the same cycle as the clear wins: that flag stays 1.
- **Mode FSM.** States ADD, SUB, XOR. A press edge on key1 → ADD, key2 → SUB, key3 → XOR, from any state. On simultaneous press edges, priority is key1 > key2 > key3. Holding a key causes no further transitions.
- **Read map.** Evaluated on `rd_en`; data appears on `rdata` on the next edge.
  - 0x00: `{22'b0, sw_stable}`
  - 0x10: `{29'b0, key_pressed}`
  - 0x14: `{29'b0, ev}` (clear-on-read)
  - 0x18: `{30'b0, mode}`
  - Any other offset: 0.
- When `rd_en` = 0, `rdata` holds its previous value and no clear occurs.

## Timing
- **Reset values.**
  - Switch synchronisers 0; key synchronisers 1 (released).
  - Stable values and counters 0.
  - `sw_stable` = 0, `key_pressed` = 0, `ev` = 0, `mode` = ADD, `rdata` = 0.
- **Reset mid-operation.** All counters clear. Any in-progress debounce is discarded. No event or mode change is produced by the reset itself, and none on the first cycle after release.
- **Input latency.** A clean raw change appears on `sw_stable`/`key_pressed` 2 + `DEBOUNCE_CYCLES` edges later.
- **Derived outputs.** `ev` and `mode` update on the edge after `key_pressed` rises.
- **Read latency.** `rdata` is valid 1 cycle after `rd_en`.
  - Back-to-back reads are allowed, one per cycle.
  - A read of 0x14 returns the pre-clear flags. A second 0x14 read in the next cycle returns 0, unless a new press edge has occurred.
- Counters never wrap; the counter is bounded by `DEBOUNCE_CYCLES-1`.

## Configuration
- Macro: `IO_INPUT_DEBOUNCE_EN`.
- **Defined:** debounce counters are built as described above.
- **Undefined:**
  - Counters are removed; stable value = synchronised value.
  - Input latency becomes 2 edges.
  - `DEBOUNCE_CYCLES` is ignored.
  - Edge, event, mode and read behaviour are unchanged.

## Structure
- Package `io_input_pkg` holds:
  - mode enum `calc_mode_t` (ADD = 0, SUB = 1, XOR = 2);
  - offset constants `IO_SW_OFS` = 0x00, `IO_KEY_OFS` = 0x10, `IO_EV_OFS` = 0x14, `IO_MODE_OFS` = 0x18.
- Sub-module `io_debounce`: one bit, containing the synchroniser, counter and stable flop, with parameters `DEBOUNCE_CYCLES` and reset value. It is instantiated 13 times (10 switches, 3 keys). The `IO_INPUT_DEBOUNCE_EN` guard lives inside this sub-module.
- Edge detection, event flags, mode FSM and read mux live in the top module.

## Test plan
Bench settings: `DEBOUNCE_CYCLES` = 4, macro defined. `sw` = 0 and all keys released unless a scenario states otherwise.

- **Reset check.** Hold `resetn` = 0 for 3 cycles with `sw` = 10'b1111100000 → all outputs 0 and `mode` = ADD. After release, `sw_stable` = 0x3E0 exactly 6 edges later.
- **Bounce rejection.** Toggle key2 low/high every 2 cycles for 20 cycles, then hold low → `key_pressed` stays 0 during bouncing, reaches 3'b010 6 edges after the steady hold, and `mode` = SUB on the next edge.
- **Mode sequence.** Clean presses of key1, then key3, with release between → `mode` goes ADD, then XOR. Key1 and key3 pressed in the same cycle → `mode` = ADD.
- **Clear-on-read.** After a key3 press, `rd_en` at 0x14 → `rdata` = 0x4. The next read of 0x14 → 0x0.
  - Same read, but key1's press edge lands in the clear cycle → second read = 0x1.
- **Read map.** `sw` = 10'b1111100000 stable, key2 held:
  - read 0x00 → 0x000003E0;
  - read 0x10 → 0x2;
  - read 0x18 → 0x1;
  - read 0x1C → 0;
  - `rd_en` = 0 → `rdata` unchanged.
- **Macro undefined.** A raw key1 change appears on `key_pressed` after 2 edges. A single-cycle glitch is passed through and produces an event.
